// File: rtl/mpmc9_resv_table.sv
// LR/SC reservation table for the mpmc9 controller: tracks NAR line reservations and answers SC requests.
// Optional reservation aging is compiled in with `define MPMC9_RESV_TIMEOUT_EN (lifetime TMO clocks).
module mpmc9_resv_table #(
    parameter int NAR = 2,
    parameter int TMO = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_ch,
    input  logic [1:0]            req_op,
    input  logic [31:0]           req_adr,
    output logic                  rsp_valid,
    output logic                  rsp_ok,
    output logic [NAR-1:0][3:0]   resv_ch,
    output logic [NAR-1:0][31:0]  resv_adr
);

    localparam int VPW = (NAR > 1) ? $clog2(NAR) : 1;
    localparam logic [3:0] CH_EMPTY = 4'hF;

    typedef enum logic [1:0] {OP_RD = 2'b00, OP_LR = 2'b01, OP_WR = 2'b10, OP_SC = 2'b11} op_e;

    if (NAR < 1 || NAR > 8 || TMO < 1 || TMO > 65535) begin : g_bad_param
        $error("mpmc9_resv_table: NAR must be 1..8 and TMO 1..65535");
    end

    // Only the line granule is stored; the low nibble of the output is constant zero.
    logic [NAR-1:0][3:0]  ch_q,  ch_d;
    logic [NAR-1:0][27:0] adr_q, adr_d;
    logic [VPW-1:0]       vp_q,  vp_d;
    logic                 ready_q;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_ok_q,    rsp_ok_d;
`ifdef MPMC9_RESV_TIMEOUT_EN
    localparam logic [15:0] TMO_AGE = 16'(TMO);
    logic [NAR-1:0][15:0] age_q, age_d;
`endif

    logic           accept;
    logic [NAR-1:0] match, own, empty;
    logic           sc_ok, lr_has_own, lr_has_empty;
    logic [VPW-1:0] lr_idx;
    logic           unused_adr_lsb;

    assign accept         = req_valid & ready_q;
    assign unused_adr_lsb = ^req_adr[3:0];

    always_comb begin
        for (int n = 0; n < NAR; n++) begin
            empty[n] = (ch_q[n] == CH_EMPTY);
            match[n] = !empty[n] && (adr_q[n] == req_adr[31:4]);
            own[n]   = !empty[n] && (ch_q[n] == req_ch);
        end
    end

    assign sc_ok        = |(match & own);
    assign lr_has_own   = |own;
    assign lr_has_empty = |empty;

    // LR target priority: the channel's own entry, then the lowest empty entry, then the victim.
    always_comb begin
        lr_idx = vp_q;
        if (lr_has_own) begin
            for (int n = 0; n < NAR; n++)
                if (own[n]) lr_idx = VPW'(n);
        end else if (lr_has_empty) begin
            for (int n = NAR - 1; n >= 0; n--)
                if (empty[n]) lr_idx = VPW'(n);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        ch_d        = ch_q;
        adr_d       = adr_q;
        vp_d        = vp_q;
        rsp_valid_d = 1'b0;
        rsp_ok_d    = rsp_ok_q;
`ifdef MPMC9_RESV_TIMEOUT_EN
        age_d = age_q;
        for (int n = 0; n < NAR; n++) begin
            if (!empty[n]) begin
                if (age_q[n] == TMO_AGE) begin
                    ch_d[n]  = CH_EMPTY;
                    adr_d[n] = '0;
                    age_d[n] = '0;
                end else begin
                    age_d[n] = age_q[n] + 16'd1;
                end
            end
        end
`endif
        // Request effects come after aging so an LR to an expiring entry wins.
        if (accept) begin
            case (op_e'(req_op))
                OP_LR: begin
                    ch_d[lr_idx]  = req_ch;
                    adr_d[lr_idx] = req_adr[31:4];
`ifdef MPMC9_RESV_TIMEOUT_EN
                    age_d[lr_idx] = '0;
`endif
                    if (!lr_has_own && !lr_has_empty)
                        vp_d = (vp_q == VPW'(NAR - 1)) ? '0 : vp_q + VPW'(1);
                end
                OP_WR: begin
                    for (int n = 0; n < NAR; n++) begin
                        if (match[n]) begin
                            ch_d[n]  = CH_EMPTY;
                            adr_d[n] = '0;
                        end
                    end
                end
                OP_SC: begin
                    rsp_valid_d = 1'b1;
                    rsp_ok_d    = sc_ok;
                    for (int n = 0; n < NAR; n++) begin
                        if (own[n] || (sc_ok && match[n])) begin
                            ch_d[n]  = CH_EMPTY;
                            adr_d[n] = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the table is a handful of flops, so it is reset directly to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= {NAR{CH_EMPTY}};
            adr_q       <= '0;
            vp_q        <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
`ifdef MPMC9_RESV_TIMEOUT_EN
            age_q       <= '0;
`endif
        end else begin
            ch_q        <= ch_d;
            adr_q       <= adr_d;
            vp_q        <= vp_d;
            ready_q     <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
`ifdef MPMC9_RESV_TIMEOUT_EN
            age_q       <= age_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;

    always_comb begin
        resv_ch = ch_q;
        for (int n = 0; n < NAR; n++)
            resv_adr[n] = {adr_q[n], 4'h0};
    end

endmodule

// File: tb/tb_mpmc9_resv_table.sv
// Directed bench for mpmc9_resv_table (NAR=2); the aging test runs when MPMC9_RESV_TIMEOUT_EN is defined.
module tb_mpmc9_resv_table;

    localparam int NAR = 2;
`ifdef MPMC9_RESV_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [3:0]           req_ch = 4'h0;
    logic [1:0]           req_op = 2'b00;
    logic [31:0]          req_adr = '0;
    logic                 rsp_valid;
    logic                 rsp_ok;
    logic [NAR-1:0][3:0]  resv_ch;
    logic [NAR-1:0][31:0] resv_adr;

    int compared = 0;
    int mismatched = 0;

    mpmc9_resv_table #(.NAR(NAR), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_op(req_op), .req_adr(req_adr),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .resv_ch(resv_ch), .resv_adr(resv_adr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted on the next posedge and the
    // result is visible at the following negedge, where the task returns.
    task automatic issue(input logic [3:0] ch, input logic [1:0] op, input logic [31:0] adr);
        req_valid = 1'b1;
        req_ch    = ch;
        req_op    = op;
        req_adr   = adr;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_ch0", resv_ch[0], 32'hF);
        check("rst_ch1", resv_ch[1], 32'hF);
        check("rst_adr0", resv_adr[0], 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_ok", rsp_ok, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // Reset asserted while an SC is being presented: nothing is accepted, no response.
        issue(4'd1, 2'b01, 32'h1000_0040);
        check("pre_reset_lr_ch0", resv_ch[0], 1);
        req_valid = 1'b1; req_ch = 4'd1; req_op = 2'b11; req_adr = 32'h1000_0040;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midsc_rsp_valid", rsp_valid, 0);
        end
        check("midsc_ch0", resv_ch[0], 32'hF);
        check("midsc_ch1", resv_ch[1], 32'hF);
        check("midsc_ready", req_ready, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midsc_ready_after", req_ready, 1);
        check("midsc_no_rsp", rsp_valid, 0);

        // LR then SC on the same line from the same channel.
        issue(4'd1, 2'b01, 32'h1000_0040);
        check("lr1_ch0", resv_ch[0], 1);
        check("lr1_adr0", resv_adr[0], 32'h1000_0040);
        issue(4'd1, 2'b11, 32'h1000_004C);
        check("sc1_valid", rsp_valid, 1);
        check("sc1_ok", rsp_ok, 1);
        check("sc1_ch0", resv_ch[0], 32'hF);
        check("sc1_adr0", resv_adr[0], 0);
        idle(1);
        check("sc1_pulse_end", rsp_valid, 0);
        check("sc1_ok_held", rsp_ok, 1);

        // Write from a third channel kills both reservations on the line.
        do_reset();
        issue(4'd1, 2'b01, 32'h2000_0000);
        issue(4'd2, 2'b01, 32'h2000_000C);
        check("lr2_ch1", resv_ch[1], 2);
        check("lr2_adr1_lsb0", resv_adr[1], 32'h2000_0000);
        issue(4'd3, 2'b10, 32'h2000_0008);
        check("wr_ch0", resv_ch[0], 32'hF);
        check("wr_ch1", resv_ch[1], 32'hF);
        check("wr_no_rsp", rsp_valid, 0);
        issue(4'd2, 2'b11, 32'h2000_0000);
        check("sc2_valid", rsp_valid, 1);
        check("sc2_ok", rsp_ok, 0);

        // Round-robin replacement with NAR=2.
        do_reset();
        issue(4'd1, 2'b01, 32'h4000_0000);
        issue(4'd2, 2'b01, 32'h4000_0010);
        issue(4'd3, 2'b01, 32'h4000_0020);
        check("rr_ch3_e0", resv_ch[0], 3);
        check("rr_ch2_e1", resv_ch[1], 2);
        issue(4'd4, 2'b01, 32'h4000_0030);
        check("rr_ch3_keep", resv_ch[0], 3);
        check("rr_ch4_e1", resv_ch[1], 4);
        check("rr_adr1", resv_adr[1], 32'h4000_0030);
        issue(4'd5, 2'b01, 32'h4000_0040);
        check("rr_vp_wrap", resv_ch[0], 5);
        check("rr_adr0", resv_adr[0], 32'h4000_0040);

        // Failing SC from a channel without a reservation leaves others alone.
        do_reset();
        issue(4'd1, 2'b01, 32'h3000_0000);
        issue(4'd5, 2'b11, 32'h3000_0000);
        check("scf_valid", rsp_valid, 1);
        check("scf_ok", rsp_ok, 0);
        check("scf_keep_ch", resv_ch[0], 1);
        check("scf_keep_adr", resv_adr[0], 32'h3000_0000);

        // LR by a channel that already owns an entry moves it; a successful SC clears other matches.
        issue(4'd1, 2'b01, 32'h5000_0000);
        check("relr_ch0", resv_ch[0], 1);
        check("relr_adr0", resv_adr[0], 32'h5000_0000);
        check("relr_e1_empty", resv_ch[1], 32'hF);
        issue(4'd2, 2'b01, 32'h5000_0004);
        check("lr_ch2_e1", resv_ch[1], 2);
        issue(4'd1, 2'b11, 32'h5000_0004);
        check("sc3_ok", rsp_ok, 1);
        check("sc3_clr_e0", resv_ch[0], 32'hF);
        check("sc3_clr_e1", resv_ch[1], 32'hF);
        // Failing SC still clears the requester's own entry.
        issue(4'd2, 2'b01, 32'h6000_0000);
        issue(4'd2, 2'b11, 32'h7000_0000);
        check("sc4_ok", rsp_ok, 0);
        check("sc4_own_clr", resv_ch[0], 32'hF);

`ifdef MPMC9_RESV_TIMEOUT_EN
        // Aging with TMO=4: valid through age 4, cleared on the next edge.
        do_reset();
        issue(4'd1, 2'b01, 32'h6000_0000);
        idle(4);
        check("age4_valid", resv_ch[0], 1);
        idle(1);
        check("age_expired", resv_ch[0], 32'hF);
        issue(4'd1, 2'b01, 32'h6000_0000);
        idle(4);
        issue(4'd1, 2'b01, 32'h6000_0000);
        check("refresh_valid", resv_ch[0], 1);
        idle(4);
        check("refresh_age4", resv_ch[0], 1);
        idle(1);
        check("refresh_expired", resv_ch[0], 32'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
